// File: rtl/debounce_multi.sv
// debounce_multi: N_CH-channel push-button debouncer with press/release edge pulses.
//
// Each raw input passes through a 2-FF synchroniser, then a per-channel stable
// counter that only advances on the shared slow sample tick. A new debounced level
// is accepted after STABLE_TICKS consecutive disagreeing tick samples. Press and
// release pulses are registered and line up with the first cycle of the new level.
//
// Optional feature: define DEBOUNCE_REPEAT_EN to add auto-repeat press pulses
// (first after REPEAT_DELAY ticks, then every REPEAT_RATE ticks while held).
//
// Ports:
//   clk          system clock, posedge
//   rst_n        asynchronous active-low reset
//   btn_in       raw asynchronous button inputs, active-high
//   btn_level    debounced level
//   btn_press    1-cycle pulse on debounced 0->1 (plus repeats when enabled)
//   btn_release  1-cycle pulse on debounced 1->0
//   tick         sample-tick strobe
module debounce_multi #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned CLK_DIV      = 250000,
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned REPEAT_DELAY = 100,
  parameter int unsigned REPEAT_RATE  = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic            tick
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CntW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_TICKS - 1);

  // Synchroniser
  logic [N_CH-1:0] sync1_q, sync2_q;

  // Tick generator
  logic [DivW-1:0] div_q, div_d;
  logic            tick_q, tick_d;

  // Per-channel debounce state
  logic [CntW-1:0] cnt_q [N_CH];
  logic [CntW-1:0] cnt_d [N_CH];
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] press_q, press_d;
  logic [N_CH-1:0] release_q, release_d;
  logic [N_CH-1:0] press_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    div_d  = (div_q == DivMax) ? '0 : div_q + DivW'(1);
    tick_d = (div_q == DivMax);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  // Stable counters only move on the tick cycle; any agreeing sample restarts them.
  always_comb begin
    level_d    = level_q;
    press_edge = '0;
    release_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick_q) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          cnt_d[i]      = '0;
          level_d[i]    = sync2_q[i];
          press_edge[i] = sync2_q[i];
          release_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] RepDelay = RepW'(REPEAT_DELAY);
  localparam logic [RepW-1:0] RepRate  = RepW'(REPEAT_RATE);

  logic [RepW-1:0] rep_q [N_CH];
  logic [RepW-1:0] rep_d [N_CH];
  // Set once the first repeat has fired; selects the shorter inter-repeat period.
  logic [N_CH-1:0] rep_phase_q, rep_phase_d;
  logic [N_CH-1:0] rep_fire;

  always_comb begin
    rep_phase_d = rep_phase_q;
    rep_fire    = '0;
    for (int i = 0; i < N_CH; i++) begin
      rep_d[i] = rep_q[i];
      if (!level_q[i]) begin
        // Covers the press tick too, so the count starts from 0 at the press.
        rep_d[i]       = '0;
        rep_phase_d[i] = 1'b0;
      end else if (tick_q && !release_d[i]) begin
        if ((rep_q[i] + RepW'(1)) == (rep_phase_q[i] ? RepRate : RepDelay)) begin
          rep_fire[i]    = 1'b1;
          rep_d[i]       = '0;
          rep_phase_d[i] = 1'b1;
        end else begin
          rep_d[i] = rep_q[i] + RepW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        rep_q[i] <= '0;
      end
      rep_phase_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        rep_q[i] <= rep_d[i];
      end
      rep_phase_q <= rep_phase_d;
    end
  end

  always_comb begin
    press_d = press_edge | rep_fire;
  end
`else
  always_comb begin
    press_d = press_edge;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: scoreboard of expected pulse events (cycle, press, release),
// pushed when stimulus is driven and popped when the DUT emits a pulse.
module tb_debounce_multi;

  localparam int N_CH         = 4;
  localparam int CLK_DIV      = 4;
  localparam int STABLE_TICKS = 3;
  localparam int REPEAT_DELAY = 5;
  localparam int REPEAT_RATE  = 2;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
  } ev_t;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic            tick;

  int  n_checks;
  int  n_errors;
  int  cyc;
  ev_t sb[$];

  debounce_multi #(
    .N_CH        (N_CH),
    .CLK_DIV     (CLK_DIV),
    .STABLE_TICKS(STABLE_TICKS),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the monitor sees the state after edge 'cyc'.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r);
    ev_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    sb.push_back(e);
  endtask

  // First tick-processing edge that sees an input driven on the negedge at cycle c
  // (two sync edges first); the level flips STABLE_TICKS-1 ticks later.
  function automatic int first_tick_edge(input int c);
    int e;
    e = c + 3;
    while (e % CLK_DIV != 1) e++;
    return e;
  endfunction

  function automatic int flip_edge(input int c);
    return first_tick_edge(c) + (STABLE_TICKS - 1) * CLK_DIV;
  endfunction

  task automatic wait_until(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < target) check_eq("timeout", cyc, target);
  endtask

  // Monitor
  always @(negedge clk) begin
    logic exp_tick;
    ev_t  ev;
    if (rst_n) begin
      exp_tick = (cyc > 0) && (cyc % CLK_DIV == 0);
      if (tick || exp_tick) check_eq("tick", {31'd0, tick}, {31'd0, exp_tick});
      if ((btn_press | btn_release) != 0) begin
        check_eq("both_high", {28'd0, btn_press & btn_release}, 32'd0);
        if (sb.size() == 0) begin
          check_eq("unexp_pulse", {24'd0, btn_press, btn_release}, 32'd0);
        end else begin
          ev = sb.pop_front();
          check_eq("pulse_cyc", cyc, ev.cyc);
          check_eq("press", {28'd0, btn_press}, {28'd0, ev.press});
          check_eq("release", {28'd0, btn_release}, {28'd0, ev.rel});
        end
      end
    end
  end

  initial begin
    int f;
    int e1;
    n_checks = 0;
    n_errors = 0;
    btn_in   = 4'hF;
    rst_n    = 1'b0;

    // 1: reset with all inputs high, then all channels debounce together
    repeat (3) @(negedge clk);
    check_eq("rst_level", {28'd0, btn_level}, 32'd0);
    check_eq("rst_press", {28'd0, btn_press}, 32'd0);
    check_eq("rst_release", {28'd0, btn_release}, 32'd0);
    check_eq("rst_tick", {31'd0, tick}, 32'd0);
    rst_n = 1'b1;
    f = flip_edge(0);
    push_ev(f, 4'hF, 4'h0);
    wait_until(f - 1);
    check_eq("t1_pre_lvl", {28'd0, btn_level}, 32'd0);
    wait_until(f + 1);
    check_eq("t1_lvl", {28'd0, btn_level}, 32'hF);
    btn_in = 4'h0;
    f = flip_edge(cyc);
    push_ev(f, 4'h0, 4'hF);
    wait_until(f + 1);
    check_eq("t1_rel_lvl", {28'd0, btn_level}, 32'd0);

    // 2: ch0 steady press and release
    btn_in[0] = 1'b1;
    f = flip_edge(cyc);
    push_ev(f, 4'h1, 4'h0);
    wait_until(f - 1);
    check_eq("t2_pre_lvl", {28'd0, btn_level}, 32'd0);
    wait_until(f + 8);
    check_eq("t2_hold_lvl", {28'd0, btn_level}, 32'h1);
    btn_in[0] = 1'b0;
    f = flip_edge(cyc);
    push_ev(f, 4'h0, 4'h1);
    wait_until(f + 1);
    check_eq("t2_rel_lvl", {28'd0, btn_level}, 32'd0);

    // 3: ch1 bounce never holds for 3 ticks
    for (int i = 0; i < 8; i++) begin
      btn_in[1] = (i % 2 == 0);
      repeat (5) @(negedge clk);
    end
    btn_in[1] = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t3_lvl", {28'd0, btn_level}, 32'd0);
    check_eq("t3_sb_empty", sb.size(), 32'd0);

    // 4: ch2 and ch3 together
    btn_in[3:2] = 2'b11;
    f = flip_edge(cyc);
    push_ev(f, 4'hC, 4'h0);
    wait_until(f + 1);
    check_eq("t4_lvl", {28'd0, btn_level}, 32'hC);
    btn_in[3:2] = 2'b00;
    f = flip_edge(cyc);
    push_ev(f, 4'h0, 4'hC);
    wait_until(f + 1);
    check_eq("t4_rel_lvl", {28'd0, btn_level}, 32'd0);

    // 5: reset after two disagreeing ticks discards the partial count
    btn_in[0] = 1'b1;
    e1 = first_tick_edge(cyc);
    wait_until(e1 + CLK_DIV);
    check_eq("t5_partial_lvl", {28'd0, btn_level}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t5_rst_lvl", {28'd0, btn_level}, 32'd0);
    check_eq("t5_rst_tick", {31'd0, tick}, 32'd0);
    rst_n = 1'b1;
    f = flip_edge(0);
    push_ev(f, 4'h1, 4'h0);
`ifdef DEBOUNCE_REPEAT_EN
    push_ev(f + REPEAT_DELAY * CLK_DIV, 4'h1, 4'h0);
    push_ev(f + (REPEAT_DELAY + REPEAT_RATE) * CLK_DIV, 4'h1, 4'h0);
    push_ev(f + (REPEAT_DELAY + 2 * REPEAT_RATE) * CLK_DIV, 4'h1, 4'h0);
    push_ev(f + (REPEAT_DELAY + 3 * REPEAT_RATE) * CLK_DIV, 4'h1, 4'h0);
`endif
    wait_until(f - 1);
    check_eq("t5_refill_lvl", {28'd0, btn_level}, 32'd0);
    wait_until(f + 1);
    check_eq("t5_lvl", {28'd0, btn_level}, 32'h1);

    // 6: hold ch0 so the level stays high for 12 ticks after the press
    wait_until(f + 9 * CLK_DIV);
    btn_in[0] = 1'b0;
    f = flip_edge(cyc);
    push_ev(f, 4'h0, 4'h1);
    wait_until(f + 30);
    check_eq("t6_lvl", {28'd0, btn_level}, 32'd0);
    check_eq("t6_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
